if_id_queue: RTL and testbench

Decoupling buffer between the instruction fetch unit and the instruction decode unit. Each fetched `{pc, inst}` pair is captured in a small circular FIFO and presented to decode through a valid/ready handshake. A control-flow redirect from execute can flush it, and instruction-address misalignment is flagged per entry. This lets fetch advance its PC, and assert its `pcEn`, only when an entry is actually accepted, without stalling on decode back-pressure.

---
 rtl/if_id_queue_pkg.sv | 13 +
 rtl/if_id_queue_ptr.sv | 38 +++
 rtl/if_id_queue.sv | 68 ++++++
 tb/tb_if_id_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// ifq_pkg: types and constants shared by fetch, the if/id queue and decode.
package ifq_pkg;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int ILEN = 32;
  typedef struct packed {
    logic [63:0]     pc;
    logic [ILEN-1:0] inst;
    logic            misalign;
  } ifq_entry_t;
  function automatic logic misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction
endpackage

// File: rtl/if_id_queue_ptr.sv
// ifq_ptr: read/write pointer and occupancy update for the if/id queue, with flush.
module ifq_ptr
  import ifq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  output logic [$clog2(DEPTH)-1:0] rptr,
  output logic [$clog2(DEPTH)-1:0] wptr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PW:0]   count_q, count_d;
  always_comb begin
    rptr_d  = flush ? '0 : rptr_q + PW'(pop);
    wptr_d  = flush ? '0 : wptr_q + PW'(push);
    count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end
  assign rptr  = rptr_q;
  assign wptr  = wptr_q;
  assign count = count_q;
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode circular FIFO with flush and misalign flag.
// Define IFQ_BYPASS_EN for a zero-latency path from fetch to decode when empty.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [ILEN-1:0]        in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [ILEN-1:0]        out_inst,
  output logic                   out_misalign,
  output logic [$clog2(DEPTH):0] count
);
  import ifq_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            misalign;
  } entry_t;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  entry_t        in_entry, head;
  logic [PW-1:0] rptr, wptr;
  logic          empty, push, pop, bypass;
  always_comb begin
    in_entry = '{pc: in_pc, inst: in_inst, misalign: misaligned(in_pc[1:0])};
    empty    = count == '0;
    in_ready = (count != FULL) & !flush;
`ifdef IFQ_BYPASS_EN
    out_valid = (!empty | in_valid) & !flush;
    head      = empty ? in_entry : mem_q[rptr];
`else
    out_valid = !empty & !flush;
    head      = mem_q[rptr];
`endif
    push   = in_valid & in_ready;
    pop    = out_valid & out_ready;
    // An entry consumed straight through the bypass never touches storage.
    bypass = empty & push & pop;
    mem_d  = mem_q;
    if (push & !bypass) mem_d[wptr] = in_entry;
    {out_pc, out_inst, out_misalign} = head;
  end
  always_ff @(posedge clock) begin
    if (reset) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  ifq_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push & !bypass),
    .pop   (pop & !bypass),
    .rptr  (rptr),
    .wptr  (wptr),
    .count (count)
  );
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue (DEPTH=2).
module tb_if_id_queue;
  logic        clock = 0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_misalign;
  logic [63:0] in_pc, out_pc;
  logic [31:0] in_inst, out_inst;
  logic [1:0]  count;
  int total = 0;
  int bad = 0;

  if_id_queue #(.DEPTH(2), .XLEN(64), .ILEN(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_misalign(out_misalign), .count(count)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_inst = '0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    #1;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
    total++; if (out_misalign !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", out_misalign); end
  endtask

  task automatic test_fill();
    out_ready = 0; in_valid = 1; in_pc = 64'h8000_0000; in_inst = 32'h0000_0413;
    tick();
    in_pc = 64'h8000_0004; in_inst = 32'h0000_9117;
    tick();
    in_pc = 64'h8000_0008; in_inst = 32'hdead_beef;
    #1;
    total++; if (count !== 2'd2) begin bad++; $display("FAIL fill_count got=%0d exp=2", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    total++; if (out_pc !== 64'h8000_0000) begin bad++; $display("FAIL fill_head got=%h exp=80000000", out_pc); end
    tick();
    in_valid = 0;
    #1;
    total++; if (count !== 2'd2) begin bad++; $display("FAIL refused_count got=%0d exp=2", count); end
    out_ready = 1;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pop0_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== 64'h8000_0000) begin bad++; $display("FAIL pop0_pc got=%h exp=80000000", out_pc); end
    total++; if (out_inst !== 32'h0000_0413) begin bad++; $display("FAIL pop0_inst got=%h exp=00000413", out_inst); end
    tick();
    #1;
    total++; if (out_pc !== 64'h8000_0004) begin bad++; $display("FAIL pop1_pc got=%h exp=80000004", out_pc); end
    total++; if (out_inst !== 32'h0000_9117) begin bad++; $display("FAIL pop1_inst got=%h exp=00009117", out_inst); end
    total++; if (count !== 2'd1) begin bad++; $display("FAIL pop1_count got=%0d exp=1", count); end
    tick();
    #1;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_stream();
    logic [63:0] base = 64'h8000_0100;
    logic [63:0] exp_pc;
    logic [1:0]  exp_cnt;
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 16; i++) begin
      in_pc = base + 64'(4 * i); in_inst = 32'(i);
      #1;
`ifdef IFQ_BYPASS_EN
      exp_pc = base + 64'(4 * i); exp_cnt = 2'd0;
`else
      exp_pc = base + 64'(4 * (i - 1)); exp_cnt = 2'd1;
`endif
      if (i > 0) begin
        total++; if (out_pc !== exp_pc) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, exp_pc); end
        total++; if (count !== exp_cnt) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", i, count, exp_cnt); end
      end
      tick();
    end
    in_valid = 0;
    tick();
    #1;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL stream_drain got=%0d exp=0", count); end
    out_ready = 0;
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_pc = 64'h8000_0200; in_inst = 32'h1;
    tick();
    in_pc = 64'h8000_0204; in_inst = 32'h2;
    tick();
    #1;
    total++; if (count !== 2'd2) begin bad++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
    flush = 1; in_pc = 64'h8000_0bad; in_inst = 32'hbad;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      total++; if (count !== 2'd0) begin bad++; $display("FAIL flush_hold_count[%0d] got=%0d exp=0", i, count); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_hold_ready[%0d] got=%b exp=0", i, in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_hold_valid[%0d] got=%b exp=0", i, out_valid); end
    end
    flush = 0; in_pc = 64'h8000_0300; in_inst = 32'h3;
    tick();
    in_valid = 0;
    #1;
    total++; if (count !== 2'd1) begin bad++; $display("FAIL post_flush_count got=%0d exp=1", count); end
    total++; if (out_pc !== 64'h8000_0300) begin bad++; $display("FAIL post_flush_pc got=%h exp=80000300", out_pc); end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_misalign();
    out_ready = 0; in_valid = 1; in_pc = 64'h8000_0002; in_inst = 32'h13;
    tick();
    in_pc = 64'h8000_0008;
    tick();
    in_valid = 0;
    #1;
    total++; if (out_pc !== 64'h8000_0002) begin bad++; $display("FAIL mis_pc got=%h exp=80000002", out_pc); end
    total++; if (out_misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", out_misalign); end
    out_ready = 1;
    tick();
    #1;
    total++; if (out_pc !== 64'h8000_0008) begin bad++; $display("FAIL aligned_pc got=%h exp=80000008", out_pc); end
    total++; if (out_misalign !== 1'b0) begin bad++; $display("FAIL aligned_flag got=%b exp=0", out_misalign); end
    tick();
    out_ready = 0;
  endtask

  task automatic test_midreset();
    in_valid = 1; in_pc = 64'h8000_0404; in_inst = 32'h77;
    tick();
    in_valid = 0; reset = 1;
    tick();
    reset = 0;
    #1;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL midreset_pc got=%h exp=0", out_pc); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_bypass();
    in_valid = 1; out_ready = 1; in_pc = 64'h8000_0010; in_inst = 32'h55;
    #1;
`ifdef IFQ_BYPASS_EN
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== 64'h8000_0010) begin bad++; $display("FAIL bypass_pc got=%h exp=80000010", out_pc); end
    tick();
    in_valid = 0;
    #1;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nobypass_valid got=%b exp=0", out_valid); end
    tick();
    in_valid = 0;
    #1;
    total++; if (count !== 2'd1) begin bad++; $display("FAIL nobypass_count got=%0d exp=1", count); end
    total++; if (out_pc !== 64'h8000_0010) begin bad++; $display("FAIL nobypass_pc got=%h exp=80000010", out_pc); end
    tick();
    #1;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL nobypass_drain got=%0d exp=0", count); end
`endif
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_misalign();
    test_midreset();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
